// File: rtl/cnt_match_irq_pkg.sv
// Shared definitions for the counter compare/wrap interrupt block.
package cnt_match_irq_pkg;

  localparam int CNT_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PEND  = 2'd2
  } state_t;

  localparam int CAUSE_MATCH = 0;
  localparam int CAUSE_WRAP  = 1;

endpackage

// File: rtl/cnt_edge_det.sv
// Registers the previous count and flags compare-entry and 31->0 wrap events.
// Events are combinational from the current sample; no backpressure.
module cnt_edge_det
  import cnt_match_irq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [CNT_W-1:0] cmp_reg,
  output logic             match_ev,
  output logic             wrap_ev
);

  logic [CNT_W-1:0] prev_cnt;
  logic             prev_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_cnt <= '0;
      prev_vld <= 1'b0;
    end else begin
      prev_cnt <= cnt_in;
      prev_vld <= 1'b1;
    end
  end

  // Match only on entry, so a counter parked on the compare value fires once.
  assign match_ev = prev_vld & (cnt_in == cmp_reg) & (prev_cnt != cmp_reg);
  assign wrap_ev  = prev_vld & (&prev_cnt) & (cnt_in == '0);

endmodule

// File: rtl/cnt_match_irq.sv
// Compare-match / wrap interrupt with capture and saturating wrap count.
// irq visible the cycle after the event edge; no backpressure, held until ack.
module cnt_match_irq
  import cnt_match_irq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int OVF_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic             cmp_wr,
  input  logic             arm,
  input  logic             irq_ack,
  output logic             irq,
  output logic [1:0]       irq_cause,
  output logic [CNT_W-1:0] cap_val,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic             armed
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cmp_reg;
  logic             match_ev, wrap_ev;
  logic [1:0]       ev_cause;
  logic             irq_nxt;
  logic [1:0]       cause_nxt;
  logic [CNT_W-1:0] cap_nxt;

  cnt_edge_det #(.CNT_W(CNT_W)) u_edge_det (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .cmp_reg  (cmp_reg),
    .match_ev (match_ev),
    .wrap_ev  (wrap_ev)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_reg <= '1;
    end else if (cmp_wr) begin
      cmp_reg <= cmp_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (wrap_ev && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end

  always_comb begin
    ev_cause              = 2'b00;
    ev_cause[CAUSE_MATCH] = match_ev;
    ev_cause[CAUSE_WRAP]  = wrap_ev;
  end

  always_comb begin
    state_nxt = state;
    irq_nxt   = irq;
    cause_nxt = irq_cause;
    cap_nxt   = cap_val;
    case (state)
      IDLE: begin
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        if (match_ev || wrap_ev) begin
          state_nxt = PEND;
          irq_nxt   = 1'b1;
          cause_nxt = ev_cause;
          cap_nxt   = cnt_in;
        end
      end
      PEND: begin
        // Ack wins over any event landing in the same cycle.
        if (irq_ack) begin
          state_nxt = arm ? ARMED : IDLE;
          irq_nxt   = 1'b0;
          cause_nxt = 2'b00;
        end else begin
          cause_nxt = irq_cause | ev_cause;
        end
      end
      default: begin
        state_nxt = IDLE;
        irq_nxt   = 1'b0;
        cause_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      irq       <= 1'b0;
      irq_cause <= 2'b00;
      cap_val   <= '0;
    end else begin
      state     <= state_nxt;
      irq       <= irq_nxt;
      irq_cause <= cause_nxt;
      cap_val   <= cap_nxt;
    end
  end

  assign armed = (state == ARMED);

endmodule

// File: tb/tb_cnt_match_irq.sv
// Directed bench for cnt_match_irq with a per-cycle reference model.
module tb_cnt_match_irq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] cnt_in = '0;
  logic [4:0] cmp_val = '0;
  logic       cmp_wr = 1'b0;
  logic       arm = 1'b0;
  logic       irq_ack = 1'b0;
  logic       irq;
  logic [1:0] irq_cause;
  logic [4:0] cap_val;
  logic [7:0] ovf_cnt;
  logic       armed;

  int n_cmp = 0;
  int n_bad = 0;

  cnt_match_irq #(.CNT_W(5), .OVF_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .cmp_val   (cmp_val),
    .cmp_wr    (cmp_wr),
    .arm       (arm),
    .irq_ack   (irq_ack),
    .irq       (irq),
    .irq_cause (irq_cause),
    .cap_val   (cap_val),
    .ovf_cnt   (ovf_cnt),
    .armed     (armed)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = idle, 1 = armed, 2 = pending.
  int m_prev, m_cmp, m_mode, m_cap, m_ovf;
  bit m_pvld, m_match, m_wrap, ev_m, ev_w;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_prev = 0; m_pvld = 0; m_cmp = 31; m_mode = 0;
      m_match = 0; m_wrap = 0; m_cap = 0; m_ovf = 0;
    end else begin
      ev_m = m_pvld && (int'(cnt_in) == m_cmp) && (m_prev != m_cmp);
      ev_w = m_pvld && (m_prev == 31) && (cnt_in == 0);
      if (ev_w && m_ovf < 255) m_ovf = m_ovf + 1;
      if (m_mode == 0) begin
        if (arm) m_mode = 1;
      end else if (m_mode == 1) begin
        if (ev_m || ev_w) begin
          m_mode = 2; m_match = ev_m; m_wrap = ev_w; m_cap = int'(cnt_in);
        end
      end else begin
        if (irq_ack) begin
          m_mode = arm ? 1 : 0; m_match = 0; m_wrap = 0;
        end else begin
          m_match = m_match | ev_m; m_wrap = m_wrap | ev_w;
        end
      end
      if (cmp_wr) m_cmp = int'(cmp_val);
      m_prev = int'(cnt_in);
      m_pvld = 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("model_irq",   int'(irq),       (m_mode == 2) ? 1 : 0);
      chk("model_cause", int'(irq_cause), {m_wrap, m_match});
      chk("model_cap",   int'(cap_val),   m_cap);
      chk("model_ovf",   int'(ovf_cnt),   m_ovf);
      chk("model_armed", int'(armed),     (m_mode == 1) ? 1 : 0);
    end
  end

  // Apply one cycle of inputs at a falling edge; return at the next falling edge.
  task automatic cyc(input logic [4:0] c, input logic a, input logic k,
                     input logic w, input logic [4:0] v);
    cnt_in = c; arm = a; irq_ack = k; cmp_wr = w; cmp_val = v;
    @(negedge clk);
    arm = 1'b0; irq_ack = 1'b0; cmp_wr = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_irq",   int'(irq), 0);
    chk("rst_cause", int'(irq_cause), 0);
    chk("rst_cap",   int'(cap_val), 0);
    chk("rst_ovf",   int'(ovf_cnt), 0);
    chk("rst_armed", int'(armed), 0);
    rst = 1'b1;

    // Match on 7 from a free-running count
    cyc(5'd0, 1, 0, 1, 5'd7);
    chk("t1_armed", int'(armed), 1);
    for (int i = 1; i <= 6; i++) cyc(5'(i), 0, 0, 0, 5'd0);
    chk("t1_no_irq_yet", int'(irq), 0);
    cyc(5'd7, 0, 0, 0, 5'd0);
    chk("t1_irq", int'(irq), 1);
    chk("t1_cause", int'(irq_cause), 1);
    chk("t1_cap", int'(cap_val), 7);
    cyc(5'd8, 0, 1, 0, 5'd0);
    chk("t1_ack_irq", int'(irq), 0);
    chk("t1_ack_idle", int'(armed), 0);

    // Match on 31 followed by wrap ORs cause
    cyc(5'd9, 1, 0, 1, 5'd31);
    for (int i = 10; i <= 30; i++) cyc(5'(i), 0, 0, 0, 5'd0);
    cyc(5'd31, 0, 0, 0, 5'd0);
    chk("t2_irq", int'(irq), 1);
    chk("t2_cause_m", int'(irq_cause), 1);
    chk("t2_cap", int'(cap_val), 31);
    cyc(5'd0, 0, 0, 0, 5'd0);
    chk("t2_cause_mw", int'(irq_cause), 3);
    chk("t2_cap_hold", int'(cap_val), 31);
    chk("t2_ovf", int'(ovf_cnt), 1);
    cyc(5'd1, 0, 1, 0, 5'd0);

    // Counter parked on the compare value
    cyc(5'd5, 0, 0, 1, 5'd12);
    cyc(5'd6, 1, 0, 0, 5'd0);
    cyc(5'd12, 0, 0, 0, 5'd0);
    chk("t3_irq", int'(irq), 1);
    for (int i = 0; i < 3; i++) cyc(5'd12, 0, 0, 0, 5'd0);
    chk("t3_cause", int'(irq_cause), 1);
    cyc(5'd12, 1, 1, 0, 5'd0);
    for (int i = 0; i < 4; i++) cyc(5'd12, 0, 0, 0, 5'd0);
    chk("t3_no_reirq", int'(irq), 0);
    chk("t3_rearmed", int'(armed), 1);

    // Ack + arm in a wrap cycle
    cyc(5'd13, 0, 0, 0, 5'd0);
    cyc(5'd12, 0, 0, 0, 5'd0);
    cyc(5'd31, 0, 0, 0, 5'd0);
    chk("t4_pend", int'(irq), 1);
    cyc(5'd0, 1, 1, 0, 5'd0);
    chk("t4_irq", int'(irq), 0);
    chk("t4_cause", int'(irq_cause), 0);
    chk("t4_armed", int'(armed), 1);
    chk("t4_ovf", int'(ovf_cnt), 2);

    // Saturating wrap count while idle
    cyc(5'd13, 0, 0, 0, 5'd0);
    cyc(5'd12, 0, 0, 0, 5'd0);
    cyc(5'd12, 0, 1, 0, 5'd0);
    chk("t5_idle", int'(armed), 0);
    for (int i = 0; i < 300; i++) begin
      cyc(5'd31, 0, 0, 0, 5'd0);
      cyc(5'd0, 0, 0, 0, 5'd0);
    end
    chk("t5_ovf_sat", int'(ovf_cnt), 255);
    chk("t5_irq", int'(irq), 0);

    // Asynchronous reset while a wrap interrupt is pending
    cyc(5'd31, 1, 0, 0, 5'd0);
    cyc(5'd0, 0, 0, 0, 5'd0);
    chk("t6_irq", int'(irq), 1);
    chk("t6_cause", int'(irq_cause), 2);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_irq", int'(irq), 0);
    chk("t6_rst_cause", int'(irq_cause), 0);
    chk("t6_rst_cap", int'(cap_val), 0);
    chk("t6_rst_ovf", int'(ovf_cnt), 0);
    chk("t6_rst_armed", int'(armed), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc(5'd0, 1, 0, 0, 5'd0);
    chk("t6_no_wrap", int'(ovf_cnt), 0);
    chk("t6_armed", int'(armed), 1);
    cyc(5'd30, 0, 0, 0, 5'd0);
    cyc(5'd31, 0, 0, 0, 5'd0);
    chk("t6_cmp31_irq", int'(irq), 1);
    chk("t6_cmp31_cause", int'(irq_cause), 1);
    chk("t6_cmp31_cap", int'(cap_val), 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
